// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub unit: FSM states, overflow codes and
// format helpers that depend only on the exponent/fraction widths.
package fp_pkg;

  // Each state names the step whose result the datapath registers currently hold.
  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StAlign,
    StAdd,
    StNorm,
    StRound
  } state_e;

  localparam logic [1:0] OVF_NONE    = 2'b00;
  localparam logic [1:0] OVF_OVER    = 2'b01;
  localparam logic [1:0] OVF_UNDER   = 2'b10;
  localparam logic [1:0] OVF_SPECIAL = 2'b11;

  // Widest format the helpers can build; callers slice down to their own width.
  localparam int unsigned MaxW = 128;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN {0, all-ones exponent, 1, zeros}.
  function automatic logic [MaxW-1:0] qnan(input int unsigned exp_w, input int unsigned frac_w);
    return ((MaxW'(1) << (exp_w + 1)) - MaxW'(1)) << (frac_w - 1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]         a_i,
  output logic [$clog2(W+1)-1:0] cnt_o
);

  localparam int unsigned CntW = $clog2(W + 1);

  // Scan upwards so the most significant set bit determines the count.
  always_comb begin
    cnt_o = CntW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (a_i[i]) begin
        cnt_o = CntW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/float_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with start/done handshake, RNE rounding and
// flush-to-zero of subnormals. Operands are unpacked as they are latched; each following
// cycle performs one step, and the rounded result appears with done five samples later.
module float_addsub_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    op_i,
  input  logic [EXP_W+FRAC_W:0]   x_i,
  input  logic [EXP_W+FRAC_W:0]   y_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [EXP_W+FRAC_W:0]   z_o,
  output logic [1:0]              overflow_o
);

  localparam int unsigned W      = 1 + EXP_W + FRAC_W;
  // Significand layout: carry, hidden, fraction, guard, round, sticky.
  localparam int unsigned SW     = FRAC_W + 5;
  localparam int unsigned EW2    = EXP_W + 2;
  localparam int unsigned LzW    = SW - 1;
  localparam int unsigned LzCntW = $clog2(LzW + 1);
  localparam int unsigned ShMax  = FRAC_W + 3;

  localparam logic [MaxW-1:0]       QNanFull = qnan(EXP_W, FRAC_W);
  localparam logic [W-1:0]          QNan     = QNanFull[W-1:0];
  localparam logic signed [EW2-1:0] EMax     = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW2-1:0] EOne     = EW2'(1);

  state_e                  state_q, state_d;
  logic                    sa_q, sa_d, sb_q, sb_d, s_q, s_d;
  logic [EXP_W-1:0]        ea_q, ea_d, eb_q, eb_d;
  logic [SW-1:0]           ma_q, ma_d, mb_q, mb_d, m_q, m_d;
  logic signed [EW2-1:0]   e_q, e_d;
  logic                    byp_q, byp_d;
  logic [W-1:0]            byp_z_q, byp_z_d;
  logic [1:0]              byp_ovf_q, byp_ovf_d;
  logic [W-1:0]            z_q, z_d;
  logic [1:0]              ovf_q, ovf_d;
  logic                    done_q, done_d;

  // Unpack signals
  logic                    sx, sy, x_zero, y_zero, x_nan, y_nan, x_inf, y_inf, x_ge;
  logic [EXP_W-1:0]        ex, ey;
  logic [FRAC_W-1:0]       fx, fy;
  logic                    u_byp;
  logic [W-1:0]            u_byp_z;
  logic [1:0]              u_byp_ovf;
  // Step results
  logic [EXP_W-1:0]        diff, sh;
  logic [SW-1:0]           mask, mb_al, sum, nm;
  logic signed [EW2-1:0]   ne, re;
  logic [LzCntW-1:0]       lz;
  logic                    inc;
  logic [FRAC_W+1:0]       mant;
  logic [FRAC_W-1:0]       rfrac;
  logic [W-1:0]            rz;
  logic [1:0]              rovf;

  // Classify the incoming operands and resolve cases that bypass the arithmetic.
  always_comb begin
    sx     = x_i[W-1];
    sy     = y_i[W-1] ^ op_i;
    ex     = x_i[W-2:FRAC_W];
    ey     = y_i[W-2:FRAC_W];
    fx     = x_i[FRAC_W-1:0];
    fy     = y_i[FRAC_W-1:0];
    x_zero = (ex == '0);
    y_zero = (ey == '0);
    x_nan  = (&ex) && (fx != '0);
    y_nan  = (&ey) && (fy != '0);
    x_inf  = (&ex) && (fx == '0);
    y_inf  = (&ey) && (fy == '0);
    x_ge   = {ex, fx} >= {ey, fy};

    u_byp     = 1'b1;
    u_byp_z   = '0;
    u_byp_ovf = OVF_NONE;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      u_byp_z   = QNan;
      u_byp_ovf = OVF_SPECIAL;
    end else if (x_inf) begin
      u_byp_z   = {sx, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      u_byp_ovf = OVF_SPECIAL;
    end else if (y_inf) begin
      u_byp_z   = {sy, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      u_byp_ovf = OVF_SPECIAL;
    end else if (x_zero && y_zero) begin
      u_byp_z = {sx & sy, {(W-1){1'b0}}};
    end else if (x_zero) begin
      u_byp_z = {sy, y_i[W-2:0]};
    end else if (y_zero) begin
      u_byp_z = x_i;
    end else begin
      u_byp = 1'b0;
    end
  end

  // Align the smaller operand; shifted-out bits collapse into sticky.
  always_comb begin
    diff  = ea_q - eb_q;
    sh    = (32'(diff) > ShMax) ? EXP_W'(ShMax) : diff;
    mask  = ~({SW{1'b1}} << sh);
    mb_al = (mb_q >> sh) | {{(SW-1){1'b0}}, |(mb_q & mask)};
  end

  // Operand a always has the larger magnitude, so the difference is never negative.
  always_comb begin
    sum = (sa_q ^ sb_q) ? (ma_q - mb_q) : (ma_q + mb_q);
  end

  fp_lzc #(
    .W (LzW)
  ) u_lzc (
    .a_i   (m_q[SW-2:0]),
    .cnt_o (lz)
  );

  // Normalise so the hidden bit is set, tracking the exponent in signed extended width.
  always_comb begin
    if (m_q[SW-1]) begin
      nm = {1'b0, m_q[SW-1:2], m_q[1] | m_q[0]};
      ne = e_q + EOne;
    end else begin
      nm = m_q << lz;
      ne = e_q - $signed(EW2'(lz));
    end
  end

  // Round to nearest even and saturate to inf or flush to zero.
  always_comb begin
    inc  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    mant = {1'b0, m_q[SW-2:3]} + {{(FRAC_W+1){1'b0}}, inc};
    if (mant[FRAC_W+1]) begin
      rfrac = mant[FRAC_W:1];
      re    = e_q + EOne;
    end else begin
      rfrac = mant[FRAC_W-1:0];
      re    = e_q;
    end
    if (re >= EMax) begin
      rz   = {s_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rovf = OVF_OVER;
    end else if (re[EW2-1] || (re == '0)) begin
      rz   = {s_q, {(W-1){1'b0}}};
      rovf = OVF_UNDER;
    end else begin
      rz   = {s_q, re[EXP_W-1:0], rfrac};
      rovf = OVF_NONE;
    end
  end

  // Sequencer and datapath register next-state.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    s_d       = s_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    m_d       = m_q;
    e_d       = e_q;
    byp_d     = byp_q;
    byp_z_d   = byp_z_q;
    byp_ovf_d = byp_ovf_q;
    z_d       = z_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sa_d      = x_ge ? sx : sy;
          sb_d      = x_ge ? sy : sx;
          ea_d      = x_ge ? ex : ey;
          eb_d      = x_ge ? ey : ex;
          ma_d      = {2'b01, (x_ge ? fx : fy), 3'b000};
          mb_d      = {2'b01, (x_ge ? fy : fx), 3'b000};
          byp_d     = u_byp;
          byp_z_d   = u_byp_z;
          byp_ovf_d = u_byp_ovf;
          state_d   = StUnpack;
        end
      end
      StUnpack: begin
        mb_d    = mb_al;
        state_d = StAlign;
      end
      StAlign: begin
        m_d = sum;
        e_d = $signed({2'b00, ea_q});
        s_d = sa_q;
        // Exact cancellation yields +0 rather than a signed zero.
        if (!byp_q && (sum == '0)) begin
          byp_d     = 1'b1;
          byp_z_d   = '0;
          byp_ovf_d = OVF_NONE;
        end
        state_d = StAdd;
      end
      StAdd: begin
        m_d     = nm;
        e_d     = ne;
        state_d = StNorm;
      end
      StNorm: begin
        z_d     = byp_q ? byp_z_q : rz;
        ovf_d   = byp_q ? byp_ovf_q : rovf;
        done_d  = 1'b1;
        state_d = StRound;
      end
      StRound: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      s_q       <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      m_q       <= '0;
      e_q       <= '0;
      byp_q     <= 1'b0;
      byp_z_q   <= '0;
      byp_ovf_q <= OVF_NONE;
      z_q       <= '0;
      ovf_q     <= OVF_NONE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      s_q       <= s_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      m_q       <= m_d;
      e_q       <= e_d;
      byp_q     <= byp_d;
      byp_z_q   <= byp_z_d;
      byp_ovf_q <= byp_ovf_d;
      z_q       <= z_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign z_o        = z_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_float_addsub_seq.sv
// Directed bench for float_addsub_seq (binary32): vector table plus handshake sequences.
module tb_float_addsub_seq;

  logic        clk = 1'b0;
  logic        rst, start, op, busy, done;
  logic [31:0] x, y, z;
  logic [1:0]  ovf;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ndone;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [31:0] z;
    logic [1:0]  ovf;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  float_addsub_seq #(
    .EXP_W  (8),
    .FRAC_W (23)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .x_i        (x),
    .y_i        (y),
    .busy_o     (busy),
    .done_o     (done),
    .z_o        (z),
    .overflow_o (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Issue one operation and wait (bounded) for done; done must land on the fifth sample.
  task automatic run_op(input int idx, input vec_t v);
    int cnt;
    @(negedge clk);
    x = v.x; y = v.y; op = v.op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    check($sformatf("v%0d_latency", idx), 32'(cnt), 32'd5);
    check($sformatf("v%0d_z", idx), z, v.z);
    check($sformatf("v%0d_ovf", idx), {30'b0, ovf}, {30'b0, v.ovf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00};
    vecs[2]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 2'b00};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00};
    vecs[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 2'b00};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01};
    vecs[6]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 2'b10};
    vecs[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b11};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11};
    vecs[9]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 2'b11};
    vecs[10] = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 2'b00};
    vecs[11] = '{32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 2'b00};
    vecs[12] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2'b00};
    vecs[13] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 2'b00};
    vecs[14] = '{32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000, 2'b00};
    vecs[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2'b11};
    vecs[16] = '{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 2'b00};
    vecs[17] = '{32'h3F800000, 32'h3F800001, 1'b0, 32'h40000000, 2'b00};
    vecs[18] = '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 2'b00};
    vecs[19] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 2'b01};

    rst = 1'b1; start = 1'b0; op = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_z", z, 32'd0);
    check("rst_ovf", {30'b0, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) run_op(i, vecs[i]);

    // Busy/done trace with a stray start two edges after acceptance.
    @(negedge clk);
    x = 32'h3F800000; y = 32'h3F800000; op = 1'b0; start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (c <= 7) check($sformatf("trace_busy_c%0d", c), {31'b0, busy}, (c <= 5) ? 32'd1 : 32'd0);
      start = (c == 2);
      x = (c == 2) ? 32'h40400000 : 32'h3F800000;
    end
    check("trace_ndone", 32'(ndone), 32'd1);
    check("trace_z", z, 32'h40000000);

    // Reset three edges into an operation aborts it without a done.
    @(negedge clk);
    x = 32'h3F800000; y = 32'h3FC00000; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_z", z, 32'd0);
    check("abort_ovf", {30'b0, ovf}, 32'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", 32'(ndone), 32'd0);

    // Start held high: ignored while busy and in the done cycle, accepted on the next edge.
    @(negedge clk);
    x = 32'h40000000; y = 32'h3F800000; op = 1'b0; start = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (c == 5) begin
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_z1", z, 32'h40400000);
        x = 32'h40400000; y = 32'h3F800000; op = 1'b1;
      end
      if (c == 11) begin
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_z2", z, 32'h40000000);
      end
      start = (c <= 6);
    end
    check("b2b_ndone", 32'(ndone), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
